// File: rtl/nios_mul_pkg.sv
// Shared constants and types for the Nios II multiplier back end.
// Also holds the arithmetic used to fold the partial products into the low product word.
package nios_mul_pkg;

    localparam int MUL_W         = 32;
    localparam int HALF_W        = 16;
    localparam int DEFAULT_TAG_W = 5;

    typedef struct packed {
        logic [MUL_W-1:0] p1;
        logic [MUL_W-1:0] p2;
        logic [MUL_W-1:0] p3;
    } pp_bundle_t;

    // Only the low halves of the cross products reach bits [31:16] of the product.
    function automatic logic [HALF_W-1:0] mid_sum(
        input logic [HALF_W-1:0] p2_lo,
        input logic [HALF_W-1:0] p3_lo
    );
        return p2_lo + p3_lo;
    endfunction

    function automatic logic [MUL_W-1:0] low_word(
        input logic [MUL_W-1:0]  p1,
        input logic [HALF_W-1:0] mid
    );
        return p1 + {mid, {HALF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/nios_mul_pipe_slice.sv
// One-entry valid/ready register slice with flush.
// Accepts whenever empty or draining, so back-to-back transfers run without bubbles.
module nios_mul_pipe_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;
    logic         accept;

    assign in_ready  = !valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Flush clears only the valid bit; data is left alone and a flushed input is dropped.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        accept  = in_valid & in_ready & !flush;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (valid_q & out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/nios_mul_combine.sv
// Reduces the three 16x16 partial products to the low 32 bits of a 32x32 product
// through a two-stage valid/ready pipeline carrying a destination tag.
module nios_mul_combine
    import nios_mul_pkg::*;
#(
    parameter int TAG_W = DEFAULT_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_p1,
    input  logic [31:0]      in_p2,
    input  logic [31:0]      in_p3,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int S1_W = TAG_W + MUL_W + HALF_W;
    localparam int S2_W = TAG_W + MUL_W;

    pp_bundle_t        pp;
    logic [HALF_W-1:0] in_mid;
    logic [S1_W-1:0]   s1_in_data;
    logic [S1_W-1:0]   s1_data;
    logic              s1_valid;
    logic [TAG_W-1:0]  s1_tag;
    logic [MUL_W-1:0]  s1_p1;
    logic [HALF_W-1:0] s1_mid;
    logic [S2_W-1:0]   s2_in_data;
    logic [S2_W-1:0]   s2_data;
    logic              s2_valid;
    logic              s2_free;
    logic              unused_upper;

    assign pp = '{p1: in_p1, p2: in_p2, p3: in_p3};

    // The upper halves of the cross products only contribute above bit 31.
    assign unused_upper = ^{pp.p2[MUL_W-1:HALF_W], pp.p3[MUL_W-1:HALF_W]};

    always_comb begin
        in_mid     = mid_sum(pp.p2[HALF_W-1:0], pp.p3[HALF_W-1:0]);
        s1_in_data = {in_tag, pp.p1, in_mid};
    end

    nios_mul_pipe_slice #(
        .W (S1_W)
    ) u_stage1 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in_data),
        .out_valid (s1_valid),
        .out_ready (s2_free),
        .out_data  (s1_data)
    );

    always_comb begin
        {s1_tag, s1_p1, s1_mid} = s1_data;
        s2_in_data              = {s1_tag, low_word(s1_p1, s1_mid)};
    end

    nios_mul_pipe_slice #(
        .W (S2_W)
    ) u_stage2 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (s1_valid),
        .in_ready  (s2_free),
        .in_data   (s2_in_data),
        .out_valid (s2_valid),
        .out_ready (out_ready),
        .out_data  (s2_data)
    );

    always_comb begin
        out_valid           = s2_valid;
        {out_tag, out_result} = s2_data;
        busy                = s1_valid | s2_valid;
    end

endmodule

// File: tb/tb_nios_mul_combine.sv
// Directed bench for nios_mul_combine: latency, wrap, streaming, backpressure, flush and reset.
// Inputs change 1ns after a rising edge; outputs are sampled on the falling edge.
module tb_nios_mul_combine;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_p1, in_p2, in_p3;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;

    int check_count = 0;
    int pass_count  = 0;

    always #5 clk = ~clk;

    nios_mul_combine #(
        .TAG_W (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_p1      (in_p1),
        .in_p2      (in_p2),
        .in_p3      (in_p3),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] p1, input logic [31:0] p2,
                                 input logic [31:0] p3, input logic [4:0] tag,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        in_p1     = p1;
        in_p2     = p2;
        in_p3     = p3;
        in_tag    = tag;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One operation through an idle pipe with out_ready=1: result two cycles after accept.
    task automatic runSingle(input string name, input logic [31:0] p1, input logic [31:0] p2,
                             input logic [31:0] p3, input logic [4:0] tag, input logic [31:0] exp_res);
        applyStimulus(1'b1, p1, p2, p3, tag, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput({name, "_lat1_valid"}, out_valid, 0);
        checkOutput({name, "_lat1_busy"}, busy, 1);
        nextCycle();
        @(negedge clk);
        checkOutput({name, "_valid"}, out_valid, 1);
        checkOutput({name, "_result"}, out_result, exp_res);
        checkOutput({name, "_tag"}, out_tag, tag);
        nextCycle();
    endtask

    logic [31:0] src1_tab [8] = '{32'h0000_0001, 32'h0001_0001, 32'hFFFF_FFFF, 32'h1234_5678,
                                   32'h8000_0000, 32'h0000_FFFF, 32'hDEAD_BEEF, 32'h0003_0002};
    logic [31:0] src2_tab [8] = '{32'h0000_0007, 32'h0001_0001, 32'hFFFF_FFFF, 32'h0000_0010,
                                   32'h0000_0002, 32'h0000_FFFF, 32'h0001_0000, 32'h0005_0004};
    logic [31:0] exp_tab  [8];

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] full;
        logic [31:0] s1, s2;

        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
        #12;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_result", out_result, 0);
        checkOutput("rst_out_tag", out_tag, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_in_ready", in_ready, 1);

        // Released mid-cycle; the first accept happens on the very next edge.
        reset = 1'b0;
        runSingle("basic", 32'h0000_000F, 32'h0000_0006, 32'h0000_0005, 5'd3, 32'h000B_000F);
        @(negedge clk);
        checkOutput("basic_drained", out_valid, 0);
        checkOutput("basic_idle_busy", busy, 0);
        nextCycle();

        runSingle("wrap", 32'h0000_0001, 32'hFFFF_0001, 32'h0000_FFFF, 5'd7, 32'h0000_0001);

        $display("[TB] back-to-back stream");
        for (int i = 0; i < 8; i++) begin
            full       = {32'h0, src1_tab[i]} * {32'h0, src2_tab[i]};
            exp_tab[i] = full[31:0];
        end
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                s1 = src1_tab[c];
                s2 = src2_tab[c];
                applyStimulus(1'b1, s1[15:0] * s2[15:0], s1[15:0] * s2[31:16],
                              s1[31:16] * s2[15:0], 5'(c + 10), 1'b1, 1'b0);
            end else begin
                applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
            end
            @(negedge clk);
            if (c < 8) checkOutput($sformatf("b2b_in_ready_%0d", c), in_ready, 1);
            checkOutput($sformatf("b2b_valid_%0d", c), out_valid, (c >= 2) ? 1 : 0);
            if (c >= 2) begin
                checkOutput($sformatf("b2b_result_%0d", c - 2), out_result, exp_tab[c - 2]);
                checkOutput($sformatf("b2b_tag_%0d", c - 2), out_tag, 64'(c + 8));
            end
            nextCycle();
        end

        $display("[TB] backpressure");
        applyStimulus(1'b1, 32'h0000_0011, 32'h0000_0002, 32'h0000_0003, 5'd1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("bp_ready0", in_ready, 1);
        nextCycle();
        applyStimulus(1'b1, 32'h1234_5678, 32'h0000_0001, 32'h0000_0001, 5'd2, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("bp_ready1", in_ready, 1);
        checkOutput("bp_valid1", out_valid, 0);
        nextCycle();
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'd4, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("bp_full_ready", in_ready, 0);
        checkOutput("bp_full_valid", out_valid, 1);
        checkOutput("bp_full_result", out_result, 32'h0005_0011);
        checkOutput("bp_full_tag", out_tag, 1);
        nextCycle();
        @(negedge clk);
        checkOutput("bp_hold_ready", in_ready, 0);
        checkOutput("bp_hold_result", out_result, 32'h0005_0011);
        checkOutput("bp_hold_tag", out_tag, 1);
        checkOutput("bp_hold_busy", busy, 1);
        nextCycle();
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_ready", in_ready, 1);
        checkOutput("bp_release_result", out_result, 32'h0005_0011);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("bp_drain_b_result", out_result, 32'h1236_5678);
        checkOutput("bp_drain_b_tag", out_tag, 2);
        nextCycle();
        @(negedge clk);
        checkOutput("bp_drain_c_valid", out_valid, 1);
        checkOutput("bp_drain_c_result", out_result, 32'h0000_FFFF);
        checkOutput("bp_drain_c_tag", out_tag, 4);
        nextCycle();
        @(negedge clk);
        checkOutput("bp_empty_valid", out_valid, 0);
        checkOutput("bp_empty_busy", busy, 0);

        $display("[TB] flush");
        applyStimulus(1'b1, 32'h0000_0021, 32'h0000_0001, 32'h0000_0001, 5'd5, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0022, 32'h0000_0002, 32'h0000_0002, 5'd6, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 32'h0000_DEAD, 32'h0000_0009, 32'h0000_0009, 5'd9, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("flush_pre_busy", busy, 1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("flush_valid", out_valid, 0);
        checkOutput("flush_busy", busy, 0);
        checkOutput("flush_in_ready", in_ready, 1);
        nextCycle();
        runSingle("post_flush", 32'h0000_0100, 32'h0000_0003, 32'h0000_0004, 5'd12, 32'h0007_0100);

        $display("[TB] reset with two in flight");
        applyStimulus(1'b1, 32'h0000_0031, 32'h0000_0001, 32'h0000_0000, 5'd13, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0032, 32'h0000_0000, 32'h0000_0001, 5'd14, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("prerst_valid", out_valid, 1);
        checkOutput("prerst_result", out_result, 32'h0001_0031);
        #1 reset = 1'b1;
        #1;
        checkOutput("midrst_valid", out_valid, 0);
        checkOutput("midrst_result", out_result, 0);
        checkOutput("midrst_tag", out_tag, 0);
        checkOutput("midrst_in_ready", in_ready, 1);
        checkOutput("midrst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        runSingle("post_reset", 32'hFFFF_0000, 32'h0000_8000, 32'h0000_8000, 5'd31, 32'hFFFF_0000);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
